// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Buffers WORD_WIDTH-bit words in a FIFO_DEPTH-entry FIFO and feeds them
//   LSB-first, one byte at a time, into a UART transmitter. It uses a
//   strobe/done handshake: it waits for an idle transmitter, pulses o_Tx_DV
//   for one cycle, then waits for a rising edge of i_Tx_Done.
//
//   Optional feature (macro UART_TX_FEEDER_HDR_EN): when defined, a HEADER
//   state sends the byte 8'hA5 ahead of the data bytes of every word.
//
// Ports
//   i_Clock       sole clock, rising edge
//   i_Rst_n       synchronous active-low reset
//   i_Word_DV     upstream word valid
//   i_Word        upstream word
//   o_Word_Ready  FIFO not full
//   o_Tx_DV       registered one-cycle byte strobe
//   o_Tx_Byte     registered byte, held from strobe until done
//   i_Tx_Active   transmitter busy
//   i_Tx_Done     transmitter done (level, may last several cycles)
//   o_Busy        FSM not idle or FIFO non-empty
//   o_Fifo_Count  registered FIFO occupancy
module uart_tx_feeder #(
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_n,
    input  logic                          i_Word_DV,
    input  logic [WORD_WIDTH-1:0]         i_Word,
    output logic                          o_Word_Ready,
    output logic                          o_Tx_DV,
    output logic [7:0]                    o_Tx_Byte,
    input  logic                          i_Tx_Active,
    input  logic                          i_Tx_Done,
    output logic                          o_Busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int NB = WORD_WIDTH / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, LOAD, ARM, STROBE, WAIT_DONE
`ifdef UART_TX_FEEDER_HDR_EN
        , HEADER
`endif
    } state_t;

    state_t state_q, state_d;

    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count_q;
    logic [WORD_WIDTH-1:0] shift_q;
    logic [IW-1:0]         idx_q;
    logic                  done_q;
    logic                  push, pop, arm_go, shift_go, tx_idle, done_rise;
`ifdef UART_TX_FEEDER_HDR_EN
    logic                  hdr_pend, hdr_go, hdr_done;
`endif

    assign o_Word_Ready = (count_q < DEPTH_C);
    assign o_Fifo_Count = count_q;
    assign o_Busy       = (state_q != IDLE) || (count_q != '0);
    assign push         = i_Word_DV && o_Word_Ready;
    // A strobe is only issued once the transmitter has fully released both
    // busy and done; this also covers a transmitter that was not reset.
    assign tx_idle      = !i_Tx_Active && !i_Tx_Done;
    // Each done high period is counted once, however long it lasts.
    assign done_rise    = i_Tx_Done && !done_q;

    // FIFO storage needs no reset; pointers and count carry validity.
    always_ff @(posedge i_Clock) begin
        if (push) mem[wr_ptr] <= i_Word;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        arm_go   = 1'b0;
        shift_go = 1'b0;
`ifdef UART_TX_FEEDER_HDR_EN
        hdr_go   = 1'b0;
        hdr_done = 1'b0;
`endif
        case (state_q)
            IDLE: if (count_q != '0) state_d = LOAD;
            LOAD: begin
                pop = 1'b1;
`ifdef UART_TX_FEEDER_HDR_EN
                state_d = HEADER;
`else
                state_d = ARM;
`endif
            end
`ifdef UART_TX_FEEDER_HDR_EN
            HEADER: if (tx_idle) begin
                hdr_go  = 1'b1;
                state_d = STROBE;
            end
`endif
            ARM: if (tx_idle) begin
                arm_go  = 1'b1;
                state_d = STROBE;
            end
            STROBE: state_d = WAIT_DONE;
            WAIT_DONE: if (done_rise) begin
`ifdef UART_TX_FEEDER_HDR_EN
                // Header byte done: data bytes start at index 0, no shift.
                if (hdr_pend) begin
                    hdr_done = 1'b1;
                    state_d  = ARM;
                end else
`endif
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    shift_go = 1'b1;
                    state_d  = ARM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // o_Tx_DV is registered on the ARM->STROBE edge, so it is high exactly
    // while the FSM sits in STROBE.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= 8'h00;
            shift_q   <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
`ifdef UART_TX_FEEDER_HDR_EN
            hdr_pend  <= 1'b0;
`endif
        end else begin
            done_q <= i_Tx_Done;
`ifdef UART_TX_FEEDER_HDR_EN
            o_Tx_DV <= arm_go || hdr_go;
            if (hdr_go) begin
                o_Tx_Byte <= 8'hA5;
                hdr_pend  <= 1'b1;
            end
            if (hdr_done) hdr_pend <= 1'b0;
`else
            o_Tx_DV <= arm_go;
`endif
            if (pop) begin
                shift_q <= mem[rd_ptr];
                idx_q   <= '0;
            end
            if (arm_go) o_Tx_Byte <= shift_q[7:0];
            if (shift_go) begin
                shift_q <= shift_q >> 8;
                idx_q   <= idx_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;
`ifdef UART_TX_FEEDER_HDR_EN
    localparam int SPW = 5;
`else
    localparam int SPW = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        word_dv = 1'b0;
    logic [31:0] word = '0;
    logic        word_ready;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active = 1'b0;
    logic        tx_done = 1'b0;
    logic        busy;
    logic [3:0]  fifo_count;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int done_len = 2;
    logic tx_stall = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    uart_tx_feeder #(.WORD_WIDTH(32), .FIFO_DEPTH(8)) dut (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Word_DV(word_dv), .i_Word(word),
        .o_Word_Ready(word_ready), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
        .i_Tx_Active(tx_active), .i_Tx_Done(tx_done), .o_Busy(busy),
        .o_Fifo_Count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    // Transmitter model: busy 3 cycles after a strobe, then done for done_len.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (tx_dv) begin
                tx_active = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                tx_active = 1'b0;
                tx_done   = 1'b1;
                repeat (done_len) @(posedge clk);
                #1;
                tx_done   = 1'b0;
            end else begin
                tx_active = tx_stall;
            end
        end
    end

    // Scoreboard consumer: every strobe must match the next expected byte.
    always @(negedge clk) begin
        if (rst_n && tx_dv) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got byte %h, required no strobe", tx_byte);
            end else begin
                exp_b = exp_q.pop_front();
                if (tx_byte !== exp_b) begin
                    errors++;
                    $display("FAIL byte_order: got %h, required %h", tx_byte, exp_b);
                end
            end
            checks++;
            if (tx_done !== 1'b0) begin
                errors++;
                $display("FAIL strobe_during_done: done=%b, required 0", tx_done);
            end
        end
    end

    function automatic void exp_word(input logic [31:0] w);
`ifdef UART_TX_FEEDER_HDR_EN
        exp_q.push_back(8'hA5);
`endif
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endfunction

    task automatic push_word(input logic [31:0] w);
        @(negedge clk);
        word_dv = 1'b1;
        word    = w;
        @(negedge clk);
        word_dv = 1'b0;
        exp_word(w);
    endtask

    task automatic wait_strobes(input int target);
        int n = 0;
        while (strobes < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (strobes < target) begin
            errors++;
            $display("FAIL strobe_timeout: got %0d strobes, required %0d", strobes, target);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b pending=%0d, required busy=0 pending=0", busy, exp_q.size());
        end
        checks++;
        if (fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL idle_count: got %0d, required 0", fifo_count);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (fifo_count !== 4'd0 || word_ready !== 1'b1 || busy !== 1'b0 ||
            tx_dv !== 1'b0 || tx_byte !== 8'h00) begin
            errors++;
            $display("FAIL %s: count=%0d ready=%b busy=%b dv=%b byte=%h, required 0 1 0 0 00",
                     tag, fifo_count, word_ready, busy, tx_dv, tx_byte);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency();
        int lat = 1;
        done_len = 2;
        repeat (10) @(negedge clk);
        push_word(32'hC3B2A190);
        while (!tx_dv && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL latency: got strobe %0d cycles after accept, required 4", lat);
        end
        wait_idle();
    endtask

    task automatic test_basic();
        int base = strobes;
        int n = 0;
        done_len = 2;
        push_word(32'h44332211);
        wait_strobes(base + SPW);
        while (!tx_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_last_done: got %b, required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_last_done: got %b, required 0", busy);
        end
        wait_idle();
    endtask

    task automatic test_full();
        logic [31:0] w;
        done_len = 2;
        tx_stall = 1'b1;
        repeat (2) @(negedge clk);
        push_word($urandom);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 8) begin
                checks++;
                if (word_ready !== 1'b0 || fifo_count !== 4'd8) begin
                    errors++;
                    $display("FAIL full_flag: ready=%b count=%0d, required 0 8", word_ready, fifo_count);
                end
            end
            w = $urandom;
            word_dv = 1'b1;
            word    = w;
            if (i < 8) exp_word(w);
        end
        @(negedge clk);
        word_dv = 1'b0;
        checks++;
        if (fifo_count !== 4'd8) begin
            errors++;
            $display("FAIL full_drop: count=%0d, required 8", fifo_count);
        end
        tx_stall = 1'b0;
        wait_idle();
    endtask

    task automatic test_long_done();
        done_len = 5;
        push_word(32'h87654321);
        push_word(32'h0F1E2D3C);
        wait_idle();
        done_len = 2;
    endtask

    task automatic test_reset_mid();
        int base = strobes;
        done_len = 2;
        push_word(32'hDEADBEEF);
        push_word(32'h13572468);
        push_word(32'h9ABCDEF0);
        wait_strobes(base + SPW - 2);
        checks++;
        if (fifo_count !== 4'd2) begin
            errors++;
            $display("FAIL mid_count: got %0d, required 2", fifo_count);
        end
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("mid_reset_state");
        rst_n = 1'b1;
        base = strobes;
        repeat (40) @(negedge clk);
        checks++;
        if (strobes != base) begin
            errors++;
            $display("FAIL post_reset_strobes: got %0d, required 0", strobes - base);
        end
        push_word(32'h00000001);
        wait_idle();
    endtask

    task automatic test_same_edge();
        int base;
        int n = 0;
        done_len = 2;
        tx_stall = 1'b1;
        repeat (2) @(negedge clk);
        push_word(32'h11111111);
        repeat (4) @(negedge clk);
        base = strobes;
        push_word(32'h22222222);
        push_word(32'h33333333);
        push_word(32'h44444444);
        checks++;
        if (fifo_count !== 4'd3) begin
            errors++;
            $display("FAIL pre_count: got %0d, required 3", fifo_count);
        end
        tx_stall = 1'b0;
        wait_strobes(base + SPW);
        while (!tx_done && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (fifo_count !== 4'd3) begin
            errors++;
            $display("FAIL load_count: got %0d, required 3", fifo_count);
        end
        word_dv = 1'b1;
        word    = 32'h55555555;
        @(negedge clk);
        word_dv = 1'b0;
        exp_word(32'h55555555);
        checks++;
        if (fifo_count !== 4'd3) begin
            errors++;
            $display("FAIL push_pop_count: got %0d, required 3", fifo_count);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_basic();
        test_full();
        test_long_done();
        test_reset_mid();
        test_same_edge();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
